// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// Resolves load-use stalls, taken-branch flushes and data-memory wait
// freezes, with a memory-timeout error state and a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 200  // max MEM_WAIT cycles without ack (2..255)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        branch_taken,
  input  logic        exmem_memop,
  input  logic        dmem_ack,
  output logic        pc_write,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        timeout_err,
  output logic [15:0] stall_cycles,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  // Last wait_cnt value tolerated before declaring a memory timeout.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [15:0] LP_STALL_MAX = 16'hFFFF;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout_err;
  logic [15:0] r_stall_cycles;

  logic w_in_run;
  logic w_in_wait;
  logic w_in_err;
  logic w_freeze;
  logic w_lu;
  logic w_src_match;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_in_wait = (r_state == ST_MEM_WAIT);
  assign w_in_err  = (r_state == ST_ERR);

  // Memory not ready: stall the whole pipeline. ERR freezes permanently.
  assign w_freeze = (w_in_run & exmem_memop & ~dmem_ack)
                  | (w_in_wait & ~dmem_ack)
                  | w_in_err;

  // Load-use: the load's destination feeds the next instruction. $zero never
  // carries a real dependency, so it is excluded.
  assign w_src_match = (idex_rt == ifid_rs) | (idex_rt == ifid_rt);
  assign w_lu        = idex_memread & (idex_rt != 5'd0) & w_src_match;

  // Same-cycle control outputs; reset forces a NOP/bubble into the pipe.
  always_comb begin
    pc_write    = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_freeze) begin
      pc_write    = 1'b0;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (w_lu) begin
      // Load-use wins over a taken branch: the branch is re-resolved once
      // the load result is available.
      pc_write    = 1'b0;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  // FSM: memory wait tracking, timeout detection and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (exmem_memop && !dmem_ack) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ack) begin
            // A late ack still completes the access even on the last cycle.
            r_state <= ST_RUN;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == LP_WAIT_LAST) begin
              r_state       <= ST_ERR;
              r_timeout_err <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          // Unreachable encoding: recover to RUN.
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
    end else if (!pc_write && (r_stall_cycles != LP_STALL_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign timeout_err  = r_timeout_err;
  assign stall_cycles = r_stall_cycles;
  assign state_dbg    = r_state;

endmodule
